// File: rtl/bcd_ctrl_pkg.sv
// Shared types and helpers for the multi-digit BCD counter controller.
// Saturation instead of wrap-around is selected by defining BCD_SAT_EN.
package bcd_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        logic [3:0] r;
        if (d > BCD_MAX) r = BCD_MAX;
        else             r = d;
        return r;
    endfunction

    // One decade step with 9->0 / 0->9 wrap; inputs are always legal BCD.
    function automatic logic [3:0] bcd_next(input logic [3:0] d, input logic up);
        logic [3:0] r;
        if (up) begin
            if (d >= BCD_MAX) r = BCD_MIN;
            else              r = d + 4'd1;
        end else begin
            if (d == BCD_MIN) r = BCD_MAX;
            else              r = d - 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single decade counter stage; term flags the digit that passes a carry/borrow on.
module bcd_digit
    import bcd_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       x,
    input  logic       ld,
    input  logic [3:0] ld_val,
    output logic [3:0] q,
    output logic       term
);

    // Digit register; a load wins over a step so clear/load suppresses the tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      q <= BCD_MIN;
        else if (ld)  q <= bcd_clamp(ld_val);
        else if (en)  q <= bcd_next(q, x);
        else          q <= q;
    end

    assign term = x ? (q == BCD_MAX) : (q == BCD_MIN);

endmodule

// File: rtl/bcd_counter_ctrl.sv
// Multi-digit BCD up/down counter with run control, prescaler and target match.
// Define BCD_SAT_EN to saturate at all-9s/all-0s instead of wrapping.
module bcd_counter_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clr,
    input  logic                  x,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic [4*DIGITS-1:0]   target,
    output logic [4*DIGITS-1:0]   count,
    output logic                  z,
    output logic                  done,
    output logic                  busy
);

    localparam int            PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    state_t                state_r, state_s;
    logic [PW-1:0]         pre_r, pre_s;
    logic                  z_r, done_r, busy_r;
    logic [DIGITS-1:0]     term_s, en_s;
    logic [4*DIGITS-1:0]   q_s, next_s;
    logic                  tick_s, step_s, all_term_s, sat_s, match_s, ld_s;

    assign tick_s     = (state_r == RUN) && (pre_r == PRE_LAST);
    assign step_s     = tick_s && !clr && !load && !stop;
    assign all_term_s = &term_s;
    assign ld_s       = clr | load;
    assign match_s    = (next_s == target);

`ifdef BCD_SAT_EN
    assign sat_s = all_term_s;
`else
    assign sat_s = 1'b0;
`endif

    // Digit chain: a digit steps only when every lower digit is at its terminal value.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_lsd
            assign en_s[i] = step_s && !sat_s;
        end else begin : g_upper
            assign en_s[i] = step_s && !sat_s && (&term_s[i-1:0]);
        end

        assign next_s[4*i +: 4] = en_s[i] ? bcd_next(q_s[4*i +: 4], x) : q_s[4*i +: 4];

        bcd_digit u_digit (
            .clk    (clk),
            .rst    (rst),
            .en     (en_s[i]),
            .x      (x),
            .ld     (ld_s),
            .ld_val (clr ? BCD_MIN : load_val[4*i +: 4]),
            .q      (q_s[4*i +: 4]),
            .term   (term_s[i])
        );
    end

    // Next state; an ineffective stop lets a simultaneous start through.
    always_comb begin
        state_s = state_r;
        if (clr || load)                          state_s = IDLE;
        else if (stop && (state_r == RUN))        state_s = PAUSE;
        else if (start && (state_r != RUN))       state_s = RUN;
        else if (step_s && (match_s || sat_s))    state_s = DONE;
        else                                      state_s = state_r;
    end

    // Prescaler: restarts on entry from IDLE/DONE, keeps its phase across a pause.
    always_comb begin
        pre_s = pre_r;
        if (clr || load) begin
            pre_s = {PW{1'b0}};
        end else if (state_r == RUN) begin
            if (tick_s) pre_s = {PW{1'b0}};
            else        pre_s = pre_r + PW'(1);
        end else if (start && (state_r != PAUSE)) begin
            pre_s = {PW{1'b0}};
        end else begin
            pre_s = pre_r;
        end
    end

    // Control state and registered status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            pre_r   <= {PW{1'b0}};
            z_r     <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            pre_r   <= pre_s;
            z_r     <= step_s && all_term_s;
            done_r  <= step_s && match_s;
            busy_r  <= (state_s == RUN);
        end
    end

    assign count = q_s;
    assign z     = z_r;
    assign done  = done_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_bcd_counter_ctrl.sv
// Directed, table-driven bench for bcd_counter_ctrl (DIV=1 and DIV=3 instances).
module tb_bcd_counter_ctrl;

    typedef struct {
        logic        clr, load, start, stop, x;
        logic [15:0] lv, tg, cnt;
        logic        z, dn, bs;
    } vec_t;

    logic        clk, rst, start, stop, clr, x, load;
    logic [15:0] load_val, target;
    logic [15:0] cnt1, cnt3;
    logic        z1, done1, busy1, z3, done3, busy3;
    int          total  = 0;
    int          passed = 0;
    vec_t        tbl [0:20];

    bcd_counter_ctrl #(.DIGITS(4), .DIV(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr), .x(x),
        .load(load), .load_val(load_val), .target(target),
        .count(cnt1), .z(z1), .done(done1), .busy(busy1)
    );

    bcd_counter_ctrl #(.DIGITS(4), .DIV(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr), .x(x),
        .load(load), .load_val(load_val), .target(target),
        .count(cnt3), .z(z3), .done(done3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic c, l, s, p, xx,
                                input logic [15:0] lv, tg, cn,
                                input logic zz, dd, bb);
        vec_t v;
        v.clr = c; v.load = l; v.start = s; v.stop = p; v.x = xx;
        v.lv = lv; v.tg = tg; v.cnt = cn; v.z = zz; v.dn = dd; v.bs = bb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic apply(input vec_t v, input string nm, input bit use3);
        @(negedge clk);
        clr = v.clr; load = v.load; start = v.start; stop = v.stop; x = v.x;
        load_val = v.lv; target = v.tg;
        @(posedge clk);
        #1;
        if (use3) begin
            chk({nm, ".count"}, cnt3, v.cnt);
            chk({nm, ".z"}, 16'(z3), 16'(v.z));
            chk({nm, ".done"}, 16'(done3), 16'(v.dn));
            chk({nm, ".busy"}, 16'(busy3), 16'(v.bs));
        end else begin
            chk({nm, ".count"}, cnt1, v.cnt);
            chk({nm, ".z"}, 16'(z1), 16'(v.z));
            chk({nm, ".done"}, 16'(done1), 16'(v.dn));
            chk({nm, ".busy"}, 16'(busy1), 16'(v.bs));
        end
    endtask

    initial begin
        //            clr   load  start stop  x     load_val  target    count    z     done  busy
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h5000, 16'h0000, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1000, 16'h5000, 16'h1000, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h5000, 16'h1000, 1'b0, 1'b0, 1'b1);
        tbl[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h5000, 16'h0999, 1'b0, 1'b0, 1'b1);
        tbl[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h5000, 16'h0998, 1'b0, 1'b0, 1'b1);
        tbl[5]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h5000, 16'h0998, 1'b0, 1'b0, 1'b0);
        tbl[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h5000, 16'h0998, 1'b0, 1'b0, 1'b0);
        tbl[7]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h5000, 16'h0998, 1'b0, 1'b0, 1'b1);
        tbl[8]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h5000, 16'h0999, 1'b0, 1'b0, 1'b1);
        tbl[9]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0041, 16'h5000, 16'h0041, 1'b0, 1'b0, 1'b0);
        tbl[10] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h5000, 16'h0041, 1'b0, 1'b0, 1'b1);
        tbl[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h5000, 16'h0042, 1'b0, 1'b0, 1'b1);
        tbl[12] = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h5000, 16'h0000, 1'b0, 1'b0, 1'b0);
        tbl[13] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hF0A7, 16'h5000, 16'h9097, 1'b0, 1'b0, 1'b0);
        tbl[14] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0043, 16'h0045, 16'h0043, 1'b0, 1'b0, 1'b0);
        tbl[15] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0045, 16'h0043, 1'b0, 1'b0, 1'b1);
        tbl[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0045, 16'h0044, 1'b0, 1'b0, 1'b1);
        tbl[17] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0045, 16'h0045, 1'b0, 1'b1, 1'b0);
        tbl[18] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0045, 16'h0045, 1'b0, 1'b0, 1'b0);
        tbl[19] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0045, 16'h0045, 1'b0, 1'b0, 1'b1);
        tbl[20] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0045, 16'h0046, 1'b0, 1'b0, 1'b1);

        rst = 1'b1; start = 1'b0; stop = 1'b0; clr = 1'b0; x = 1'b1; load = 1'b0;
        load_val = 16'h0000; target = 16'h5000;
        #3;
        chk("reset.count", cnt1, 16'h0000);
        chk("reset.z", 16'(z1), 16'h0000);
        chk("reset.done", 16'(done1), 16'h0000);
        chk("reset.busy", 16'(busy1), 16'h0000);
        chk("reset.busy3", 16'(busy3), 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i <= 20; i++) apply(tbl[i], $sformatf("vec%0d", i), 1'b0);

        // Up wrap at all-9s (or saturation when built with BCD_SAT_EN)
        apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h5000, 16'h0000, 1'b0, 1'b0, 1'b0), "upw.clr", 1'b0);
        apply(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h9998, 16'h5000, 16'h9998, 1'b0, 1'b0, 1'b0), "upw.load", 1'b0);
        apply(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h5000, 16'h9998, 1'b0, 1'b0, 1'b1), "upw.start", 1'b0);
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h5000, 16'h9999, 1'b0, 1'b0, 1'b1), "upw.t1", 1'b0);
`ifdef BCD_SAT_EN
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h5000, 16'h9999, 1'b1, 1'b0, 1'b0), "upw.t2", 1'b0);
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h5000, 16'h9999, 1'b0, 1'b0, 1'b0), "upw.t3", 1'b0);
`else
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h5000, 16'h0000, 1'b1, 1'b0, 1'b1), "upw.t2", 1'b0);
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h5000, 16'h0001, 1'b0, 1'b0, 1'b1), "upw.t3", 1'b0);
`endif

        // Down from all-0s: wrap to all-9s, or hold and finish when saturating
        apply(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h5000, 16'h0000, 1'b0, 1'b0, 1'b0), "dnw.load", 1'b0);
        apply(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h5000, 16'h0000, 1'b0, 1'b0, 1'b1), "dnw.start", 1'b0);
`ifdef BCD_SAT_EN
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h5000, 16'h0000, 1'b1, 1'b0, 1'b0), "dnw.t1", 1'b0);
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h5000, 16'h0000, 1'b0, 1'b0, 1'b0), "dnw.t2", 1'b0);
`else
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h5000, 16'h9999, 1'b1, 1'b0, 1'b1), "dnw.t1", 1'b0);
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h5000, 16'h9998, 1'b0, 1'b0, 1'b1), "dnw.t2", 1'b0);
`endif

        // Asynchronous reset in the middle of a cycle while running
        apply(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h5000, 16'h1234, 1'b0, 1'b0, 1'b0), "arst.load", 1'b0);
        apply(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h5000, 16'h1234, 1'b0, 1'b0, 1'b1), "arst.start", 1'b0);
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h5000, 16'h1235, 1'b0, 1'b0, 1'b1), "arst.t1", 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.count", cnt1, 16'h0000);
        chk("arst.busy", 16'(busy1), 16'h0000);
        chk("arst.z", 16'(z1), 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h5000, 16'h0000, 1'b0, 1'b0, 1'b0), "arst.idle", 1'b0);

        // DIV=3 instance: steps every third cycle and stops on target
        apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0), "div3.clr", 1'b1);
        apply(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0), "div3.load", 1'b1);
        apply(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b1), "div3.start", 1'b1);
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b1), "div3.c1", 1'b1);
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b1), "div3.c2", 1'b1);
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0002, 16'h0001, 1'b0, 1'b0, 1'b1), "div3.c3", 1'b1);
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0002, 16'h0001, 1'b0, 1'b0, 1'b1), "div3.c4", 1'b1);
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0002, 16'h0001, 1'b0, 1'b0, 1'b1), "div3.c5", 1'b1);
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0002, 16'h0002, 1'b0, 1'b1, 1'b0), "div3.c6", 1'b1);
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0002, 16'h0002, 1'b0, 1'b0, 1'b0), "div3.c7", 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
